keypad_debounce: RTL and testbench
==================================

KEYPAD_DEBOUNCE -- requirements
Module: keypad_debounce

Interface
REQ-001 SHALL have parameter DB_COUNT, default 4, meaning consecutive matching sample ticks needed to confirm press or release; legal range 2..15.
REQ-002 SHALL have parameter REPEAT_DELAY, default 32, meaning ticks held before the first auto-repeat press; legal range 1..255.
REQ-003 SHALL have parameter REPEAT_RATE, default 8, meaning ticks between subsequent auto-repeat presses; legal range 1..255.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port tick, input, 1 bit: one-clk-wide sample strobe; it is the same enable that paces the column scan.
REQ-007 SHALL have port rows_raw, input, 4 bits: asynchronous keypad row lines, active-high.
REQ-008 SHALL have port rows_db, output, 4 bits: debounced row vector fed to the key scanner.
REQ-009 SHALL have port press, output, 1 bit: one-clk pulse per confirmed press or auto-repeat.
REQ-010 SHALL have port release, output, 1 bit: one-clk pulse per confirmed release.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-012 SHALL pass rows_raw through a 2-flop synchronizer clocked every clk; rows_s is the synchronizer output, and all decisions use rows_s only.
REQ-013 SHALL change state, counters and candidate only in cycles where tick=1; in other cycles all registers hold.
REQ-014 SHALL implement states IDLE, CONFIRM, HELD and REL_CONFIRM, using a 4-bit match counter cnt and a 4-bit candidate register cand.
REQ-015 IDLE: on tick with rows_s!=0, SHALL set cand=rows_s and cnt=1, then go to CONFIRM.
REQ-016 CONFIRM on tick: if rows_s==0, SHALL go to IDLE; if rows_s==cand, SHALL do cnt+1; if rows_s is nonzero and !=cand, SHALL set cand=rows_s and cnt=1 and stay in CONFIRM.
REQ-017 CONFIRM SHALL go to HELD on the tick where cnt+1 reaches DB_COUNT; on that transition rows_db=cand and press=1 for that single following cycle.
REQ-018 HELD on tick: if rows_s==0, SHALL set cnt=1 and go to REL_CONFIRM; any nonzero rows_s (even if different from cand) SHALL keep HELD with rows_db unchanged.
REQ-019 REL_CONFIRM on tick: if rows_s!=0, SHALL go back to HELD with no pulse and rows_db unchanged; if rows_s==0, SHALL do cnt+1.
REQ-020 REL_CONFIRM SHALL go to IDLE on the tick where cnt+1 reaches DB_COUNT; on that transition rows_db=0 and release=1 for one cycle.
REQ-021 press and release SHALL be registered, SHALL never be high in the same cycle, and SHALL last exactly one clk cycle each, regardless of tick spacing.
REQ-022 Press latency SHALL be 2 clk (synchronizer) plus DB_COUNT ticks, with the pulse in the cycle after the confirming tick; release latency SHALL follow the same rule.
REQ-023 tick held high continuously SHALL be legal and means sampling every clk.

Reset
REQ-024 reset=1 SHALL immediately force: state=IDLE, cnt=0, cand=0, synchronizer=0, rows_db=0, press=0, release=0, busy=0, repeat counter=0.
REQ-025 Reset asserted mid-operation (in any state) SHALL discard the pending confirmation and emit no release pulse.
REQ-026 After reset deasserts, a key already held SHALL be treated as a new press: it re-confirms through CONFIRM and produces one press pulse.

Configuration
REQ-027 With macro KEYPAD_REPEAT_EN defined, HELD SHALL run an 8-bit repeat counter on ticks: cleared to 0 on HELD entry, cleared again at each repeat pulse, and cleared on re-entry from REL_CONFIRM.
REQ-028 With KEYPAD_REPEAT_EN defined: an additional press pulse SHALL fire when the counter reaches REPEAT_DELAY, then every REPEAT_RATE ticks after that while the state stays in HELD.
REQ-029 With KEYPAD_REPEAT_EN undefined, the repeat counter logic SHALL be absent, and exactly one press pulse SHALL occur per HELD entry from CONFIRM.

Verification
REQ-030 Clean press, DB_COUNT=4, tick=1: rows_raw 0000->0100 held for 10 clk -> press pulse in the 6th clk after the edge; rows_db=0100; busy=1.
REQ-031 Bounce: rows_raw toggles 0100/0000 every clk for 6 clk, then holds 0100 -> no press until 4 stable ticks after bouncing stops; exactly one press pulse.
REQ-032 Release glitch: in HELD, rows_raw=0000 for 2 clk then 0100 again -> no release pulse, rows_db stays 0100; a subsequent 0000 held for 6 clk -> one release pulse and rows_db=0000.
REQ-033 Tick spacing: tick every 4th clk, clean press 1000 -> press only after 4 ticks; press width exactly 1 clk; no state change in non-tick cycles.
REQ-034 Reset: assert reset during REL_CONFIRM -> all outputs 0 immediately and no release pulse; after deassert with key held 0010 -> one new press.
REQ-035 KEYPAD_REPEAT_EN with REPEAT_DELAY=5, REPEAT_RATE=3: key held 20 ticks after confirm -> press pulses at confirm, +5, +8, +11, +14, +17 ticks; with the macro undefined -> a single pulse only.

Source files
------------

// File: rtl/keypad_debounce.sv
// Keypad row debouncer: 2-flop synchronizer, tick-paced confirm/release FSM, one-clk press/release pulses.
// Optional auto-repeat of press while held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_debounce #(
   parameter int DB_COUNT     = 4,
   parameter int REPEAT_DELAY = 32,
   parameter int REPEAT_RATE  = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic [3:0] rows_raw,
   output logic [3:0] rows_db,
   output logic       press,
   output logic       released,   // 'release' is a reserved word
   output logic       busy
);

   if (DB_COUNT < 2 || DB_COUNT > 15 || REPEAT_DELAY < 1 || REPEAT_DELAY > 255 ||
       REPEAT_RATE < 1 || REPEAT_RATE > 255) begin : g_bad_param
      $error("keypad_debounce: parameter out of legal range");
   end

   typedef enum logic [1:0] {IDLE, CONFIRM, HELD, REL_CONFIRM} state_t;

   localparam logic [3:0] DB_LAST = 4'(DB_COUNT);

   state_t     state, state_d;
   logic [3:0] sync1, rows_s;
   logic [3:0] cnt, cnt_d, cand, cand_d, db_d;
   logic       press_d, rel_d;

`ifdef KEYPAD_REPEAT_EN
   localparam logic [7:0] RPT_DELAY = 8'(REPEAT_DELAY);
   localparam logic [7:0] RPT_RATE  = 8'(REPEAT_RATE);
   logic [7:0] rpt, rpt_d;
   logic       rpt_first, rpt_first_d;   // next repeat uses the initial delay
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1  <= '0;
         rows_s <= '0;
      end else begin
         sync1  <= rows_raw;
         rows_s <= sync1;
      end
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      cand_d  = cand;
      db_d    = rows_db;
      press_d = 1'b0;
      rel_d   = 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_d       = rpt;
      rpt_first_d = rpt_first;
`endif
      if (tick) begin
         case (state)
            IDLE: begin
               if (rows_s != 4'd0) begin
                  cand_d  = rows_s;
                  cnt_d   = 4'd1;
                  state_d = CONFIRM;
               end
            end
            CONFIRM: begin
               if (rows_s == 4'd0) begin
                  cnt_d   = 4'd0;
                  state_d = IDLE;
               end else if (rows_s == cand) begin
                  if (cnt + 4'd1 == DB_LAST) begin
                     cnt_d   = 4'd0;
                     db_d    = cand;
                     press_d = 1'b1;
                     state_d = HELD;
`ifdef KEYPAD_REPEAT_EN
                     rpt_d       = 8'd0;
                     rpt_first_d = 1'b1;
`endif
                  end else begin
                     cnt_d = cnt + 4'd1;
                  end
               end else begin
                  // a different key pattern restarts the confirmation
                  cand_d = rows_s;
                  cnt_d  = 4'd1;
               end
            end
            HELD: begin
               if (rows_s == 4'd0) begin
                  cnt_d   = 4'd1;
                  state_d = REL_CONFIRM;
               end else begin
`ifdef KEYPAD_REPEAT_EN
                  if (rpt + 8'd1 == (rpt_first ? RPT_DELAY : RPT_RATE)) begin
                     press_d     = 1'b1;
                     rpt_d       = 8'd0;
                     rpt_first_d = 1'b0;
                  end else begin
                     rpt_d = rpt + 8'd1;
                  end
`endif
               end
            end
            REL_CONFIRM: begin
               if (rows_s != 4'd0) begin
                  cnt_d   = 4'd0;
                  state_d = HELD;
`ifdef KEYPAD_REPEAT_EN
                  rpt_d       = 8'd0;
                  rpt_first_d = 1'b1;
`endif
               end else if (cnt + 4'd1 == DB_LAST) begin
                  cnt_d   = 4'd0;
                  db_d    = 4'd0;
                  rel_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt + 4'd1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // pulses are cleared every clk so they stay one cycle wide whatever the tick spacing
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         cand     <= '0;
         rows_db  <= '0;
         press    <= 1'b0;
         released <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rpt       <= '0;
         rpt_first <= 1'b1;
`endif
      end else begin
         state    <= state_d;
         cnt      <= cnt_d;
         cand     <= cand_d;
         rows_db  <= db_d;
         press    <= press_d;
         released <= rel_d;
`ifdef KEYPAD_REPEAT_EN
         rpt       <= rpt_d;
         rpt_first <= rpt_first_d;
`endif
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_keypad_debounce.sv
// Self-checking bench for keypad_debounce: vector table, corner-case sequences and
// randomized stimulus compared against a run-length reference model.
module tb_keypad_debounce;
   localparam int DB = 4;
   localparam int RD = 5;
   localparam int RR = 3;

   logic       clk = 1'b0, reset = 1'b0, tick = 1'b0;
   logic [3:0] rows_raw = 4'd0;
   logic [3:0] rows_db;
   logic       press, released, busy;

   keypad_debounce #(.DB_COUNT(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
      .clk(clk), .reset(reset), .tick(tick), .rows_raw(rows_raw),
      .rows_db(rows_db), .press(press), .released(released), .busy(busy));

   always #5 clk = ~clk;

   int n_chk = 0, n_err = 0, n_press = 0, n_rel = 0, n_press_hi = 0;

   // reference model: two-sample delay line, then run lengths of matching ticks
   logic [3:0] m_s1, m_s, m_db, m_cand;
   int         m_run, m_zrun, m_rep;
   bit         m_first, m_press, m_rel;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_s1 = 0; m_s = 0; m_db = 0; m_cand = 0;
      m_run = 0; m_zrun = 0; m_rep = 0; m_first = 1; m_press = 0; m_rel = 0;
   endtask

   task automatic model_step(input logic [3:0] raw, input logic tk, input logic rst);
      logic [3:0] s;
      if (rst) begin
         model_clear();
         return;
      end
      s = m_s;
      m_press = 0; m_rel = 0;
      if (tk) begin
         if (m_db == 0) begin
            if (s == 0) m_run = 0;
            else if (m_run > 0 && s == m_cand) m_run++;
            else begin m_cand = s; m_run = 1; end
            if (m_run == DB) begin
               m_db = m_cand; m_press = 1; m_run = 0; m_zrun = 0; m_rep = 0; m_first = 1;
            end
         end else if (s == 0) begin
            m_zrun++;
            if (m_zrun == DB) begin m_db = 0; m_rel = 1; m_zrun = 0; end
         end else if (m_zrun > 0) begin
            m_zrun = 0; m_rep = 0; m_first = 1;
         end else begin
`ifdef KEYPAD_REPEAT_EN
            m_rep++;
            if (m_rep == (m_first ? RD : RR)) begin m_press = 1; m_rep = 0; m_first = 0; end
`endif
         end
      end
      m_s = m_s1;
      m_s1 = raw;
   endtask

   task automatic step(input logic [3:0] raw, input logic tk);
      rows_raw = raw;
      tick = tk;
      @(posedge clk);
      model_step(raw, tk, reset);
      #1;
      if (press) n_press++;
      if (released) n_rel++;
      chk("model rows_db", rows_db, m_db);
      chk("model press", press, m_press);
      chk("model release", released, m_rel);
      chk("model busy", busy, (m_db != 0 || m_run > 0) ? 1 : 0);
   endtask

   typedef struct {
      logic [3:0] raw;
      logic       tk;
      logic [3:0] db;
      logic       pr;
      logic       rl;
      logic       bz;
   } vec_t;

   vec_t tbl[17];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int first_k, bad, exp_off[$], got_off[$], found;
      logic pb;

      // clean press then clean release, tick every clk
      for (int i = 0; i < 10; i++)
         tbl[i] = '{4'b0100, 1'b1, (i >= 5) ? 4'b0100 : 4'b0000, (i == 5), 1'b0, (i >= 2)};
      for (int i = 0; i < 7; i++)
         tbl[10+i] = '{4'b0000, 1'b1, (i >= 5) ? 4'b0000 : 4'b0100, 1'b0, (i == 5), (i < 5)};

      model_clear();
      #1 reset = 1'b1;
      #3;
      chk("reset rows_db", rows_db, 0);
      chk("reset press", press, 0);
      chk("reset release", released, 0);
      chk("reset busy", busy, 0);
      step(4'd0, 1'b1);
      step(4'd0, 1'b1);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) step(4'd0, 1'b1);

      foreach (tbl[i]) begin
         step(tbl[i].raw, tbl[i].tk);
         chk($sformatf("vec%0d rows_db", i), rows_db, tbl[i].db);
         chk($sformatf("vec%0d press", i), press, tbl[i].pr);
         chk($sformatf("vec%0d release", i), released, tbl[i].rl);
         chk($sformatf("vec%0d busy", i), busy, tbl[i].bz);
      end

      // bounce, then stable: one press DB_COUNT+1 cycles into the stable stretch
      n_press = 0; first_k = -1;
      for (int c = 0; c < 6; c++) step((c % 2 == 0) ? 4'b0100 : 4'b0000, 1'b1);
      for (int k = 0; k < 15; k++) begin
         step(4'b0100, 1'b1);
         if (press && first_k < 0) first_k = k;
      end
      chk("bounce press count", n_press, 1);
      chk("bounce press cycle", first_k, DB + 1);
      chk("bounce rows_db", rows_db, 4'b0100);

      // short release glitch is ignored, a real release confirms once
      n_rel = 0;
      step(4'd0, 1'b1); step(4'd0, 1'b1);
      for (int k = 0; k < 6; k++) step(4'b0100, 1'b1);
      chk("glitch release count", n_rel, 0);
      chk("glitch rows_db", rows_db, 4'b0100);
      for (int k = 0; k < 6; k++) step(4'd0, 1'b1);
      chk("release count", n_rel, 1);
      chk("release rows_db", rows_db, 0);
      for (int k = 0; k < 4; k++) step(4'd0, 1'b1);

      // sparse ticks: one 1-clk pulse, state only moves after tick cycles
      n_press = 0; n_rel = 0; n_press_hi = 0; bad = 0;
      for (int k = 0; k < 80; k++) begin
         logic tk;
         pb = busy;
         tk = (k % 4 == 0);
         step((k < 40) ? 4'b1000 : 4'b0000, tk);
         if (press) n_press_hi++;
         if (busy != pb && !tk) bad++;
      end
      chk("sparse press count", n_press, 1);
      chk("sparse press width", n_press_hi, 1);
      chk("sparse release count", n_rel, 1);
      chk("sparse busy moved without tick", bad, 0);

      // reset while confirming a release
      for (int k = 0; k < 10; k++) step(4'b0100, 1'b1);
      for (int k = 0; k < 4; k++) step(4'd0, 1'b1);
      chk("pre-reset busy", busy, 1);
      chk("pre-reset rows_db", rows_db, 4'b0100);
      reset = 1'b1;
      rows_raw = 4'b0010;
      #1;
      chk("async reset rows_db", rows_db, 0);
      chk("async reset press", press, 0);
      chk("async reset release", released, 0);
      chk("async reset busy", busy, 0);
      n_press = 0; n_rel = 0;
      for (int k = 0; k < 3; k++) step(4'b0010, 1'b1);
      reset = 1'b0;
      for (int k = 0; k < 12; k++) step(4'b0010, 1'b1);
      chk("post-reset press count", n_press, 1);
      chk("post-reset release count", n_rel, 0);
      chk("post-reset rows_db", rows_db, 4'b0010);
      for (int k = 0; k < 10; k++) step(4'd0, 1'b1);

      // auto-repeat offsets over 19 ticks after the confirming tick
`ifdef KEYPAD_REPEAT_EN
      for (int off = RD; off < 20; off += RR) exp_off.push_back(off);
`endif
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         step(4'b0100, 1'b1);
         if (press) found = 1;
      end
      chk("repeat confirm seen", found, 1);
      for (int t = 1; t < 20; t++) begin
         step(4'b0100, 1'b1);
         if (press) got_off.push_back(t);
      end
      chk("repeat pulse count", got_off.size(), exp_off.size());
      for (int i = 0; i < exp_off.size() && i < got_off.size(); i++)
         chk($sformatf("repeat offset %0d", i), got_off[i], exp_off[i]);
      for (int k = 0; k < 10; k++) step(4'd0, 1'b1);

      // randomized segments with varied tick density and occasional reset
      for (int seg = 0; seg < 120; seg++) begin
         logic [3:0] v;
         int len, dense;
         v = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         len = $urandom_range(1, 12);
         dense = $urandom_range(0, 1);
         for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 79) == 0) reset = 1'b1;
            step(v, dense ? 1'b1 : ($urandom_range(0, 2) == 0));
            reset = 1'b0;
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
